// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the 8-source interrupt controller.
package irq_ctrl_pkg;

  localparam int NUM_SRC = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] CFG_ENABLE = 2'd0;
  localparam logic [1:0] CFG_EDGE   = 2'd1;
  localparam logic [1:0] CFG_CLEAR  = 2'd2;
  localparam logic [1:0] CFG_RSVD   = 2'd3;

endpackage

// File: rtl/irq_ctrl_8_rr_arbiter.sv
// Combinational round-robin pick over 8 requests; search begins one past the last grant.
module rr_arbiter_8 (
  input  logic [7:0] req,
  input  logic [2:0] last,
  output logic [2:0] gnt_id,
  output logic       gnt_valid
);

  logic [2:0] idx;

  always_comb begin
    gnt_id    = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    // k = 8 wraps to last itself, so the previous winner is searched last
    for (int k = 1; k <= 8; k++) begin
      idx = last + 3'(k);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_8.sv
// Interrupt controller: edge/level pending capture, round-robin grant, claim/complete handshake.
//   state      | meaning
//   ST_IDLE    | no request outstanding, arbitrating eligible sources
//   ST_REQ     | irq_req high, irq_id held, waiting for CPU claim
//   ST_SERVICE | source claimed, waiting for matching irq_done
module irq_ctrl_8 #(
  parameter int NUM_SRC = irq_ctrl_pkg::NUM_SRC,
  parameter int ID_W    = irq_ctrl_pkg::ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_done,
  input  logic [ID_W-1:0]    done_id,
  output logic [NUM_SRC-1:0] pending,
  output logic               busy
);

  import irq_ctrl_pkg::*;

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] edge_q, edge_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] insvc_q, insvc_d;
  logic [NUM_SRC-1:0] irq_s_q;
  logic [ID_W-1:0]    id_q, id_d;
  logic [ID_W-1:0]    last_q, last_d;

  logic [NUM_SRC-1:0] set_vec, cfg_clr, claim_clr, elig, id_oh;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_valid;

  assign id_oh = NUM_SRC'(1) << id_q;
  assign elig  = pend_q & enable_q & ~insvc_q;

  rr_arbiter_8 u_arb (
    .req       (elig),
    .last      (last_q),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
      insvc_q  <= '0;
      irq_s_q  <= '0;
      id_q     <= '0;
      last_q   <= ID_W'(NUM_SRC - 1);
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      edge_q   <= edge_d;
      pend_q   <= pend_d;
      insvc_q  <= insvc_d;
      irq_s_q  <= irq_in;
      id_q     <= id_d;
      last_q   <= last_d;
    end
  end

  always_comb begin
    enable_d  = (cfg_we && cfg_addr == CFG_ENABLE) ? cfg_wdata : enable_q;
    edge_d    = (cfg_we && cfg_addr == CFG_EDGE)   ? cfg_wdata : edge_q;
    cfg_clr   = (cfg_we && cfg_addr == CFG_CLEAR)  ? cfg_wdata : '0;
    set_vec   = irq_in & (~edge_q | ~irq_s_q);
    state_d   = state_q;
    id_d      = id_q;
    last_d    = last_q;
    insvc_d   = insvc_q;
    claim_clr = '0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_d = ST_REQ;
          id_d    = gnt_id;
        end
      end
      ST_REQ: begin
        // a disable written this cycle withdraws the request even if ack arrives too
        if (!enable_d[id_q]) begin
          state_d = ST_IDLE;
        end else if (irq_ack) begin
          state_d   = ST_SERVICE;
          claim_clr = id_oh;
          insvc_d   = insvc_q | id_oh;
        end
      end
      ST_SERVICE: begin
        if (irq_done && done_id == id_q) begin
          state_d = ST_IDLE;
          insvc_d = insvc_q & ~id_oh;
          last_d  = id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = (pend_q & ~(cfg_clr | claim_clr)) | set_vec;
  end

  always_comb begin
    irq_req = (state_q == ST_REQ);
    busy    = (state_q != ST_IDLE);
  end

  assign irq_id  = id_q;
  assign pending = pend_q;

endmodule
